// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/clear arbitration, stage occupancy tracking, post-flush
// issue blocking and saturating performance counters for a multi-lane backend.
module pipe_ctrl #(
    parameter int PIPE_NUM   = 2,
    parameter int STAGE_NUM  = 3,
    parameter int FLUSH_HOLD = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [PIPE_NUM-1:0]                  issue_i,
    input  logic [$clog2(PIPE_NUM)-1:0]          first_lane_i,
    input  logic [PIPE_NUM-1:0][STAGE_NUM-1:0]   stall_req_i,
    input  logic [PIPE_NUM-1:0][STAGE_NUM-1:0]   clr_req_i,
    input  logic [PIPE_NUM-1:0][STAGE_NUM-1:0]   clr_excl_self_i,
    output logic [PIPE_NUM-1:0][STAGE_NUM-1:0]   stall_vec_o,
    output logic [PIPE_NUM-1:0][STAGE_NUM-1:0]   clr_vec_o,
    output logic [PIPE_NUM-1:0][STAGE_NUM-1:0]   valid_o,
    output logic                                 issue_ready_o,
    output logic                                 frontend_clr_o,
    output logic [CNT_WIDTH-1:0]                 stall_cnt_o,
    output logic [CNT_WIDTH-1:0]                 flush_cnt_o
);
    localparam int FLW = $clog2(PIPE_NUM);
    localparam logic [3:0] HOLD_INIT = (FLUSH_HOLD > 0) ? 4'(FLUSH_HOLD - 1) : 4'd0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef logic [PIPE_NUM-1:0][STAGE_NUM-1:0] grid_t;
    typedef enum logic {RUN, HOLD} state_t;

    grid_t                          valid_q, valid_d;
    logic [STAGE_NUM-1:0][FLW-1:0]  fl_q, fl_d;
    state_t                         state_q, state_d;
    logic [3:0]                     hold_q, hold_d;
    logic [CNT_WIDTH-1:0]           stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]           flush_cnt_q, flush_cnt_d;

    grid_t                          stall_m, clr_m, stall_vec, clr_vec;
    logic [STAGE_NUM-1:0]           stg_stall;
    logic                           stall_acc;
    logic                           frontend_clr, issue_ready;

    // Program-order position of a lane relative to the oldest lane of a stage
    function automatic int pos_f(input int lane, input logic [FLW-1:0] first);
        int d;
        d = lane - int'(first);
        if (d < 0) d = d + PIPE_NUM;
        return d;
    endfunction

    // Requests only count when they come from an occupied slot
    always_comb begin
        stall_m = stall_req_i & valid_q;
        clr_m   = clr_req_i & valid_q;
    end

    // A stall at stage t freezes every stage at or before t, in all lanes
    always_comb begin
        stg_stall = '0;
        stall_vec = '0;
        stall_acc = 1'b0;
        for (int s = STAGE_NUM - 1; s >= 0; s--) begin
            for (int q = 0; q < PIPE_NUM; q++) stall_acc = stall_acc | stall_m[q][s];
            stg_stall[s] = stall_acc;
        end
        for (int p = 0; p < PIPE_NUM; p++)
            for (int s = 0; s < STAGE_NUM; s++) stall_vec[p][s] = stg_stall[s];
    end

    // Each clear kills everything younger than its requester; requests OR together
    always_comb begin
        clr_vec      = '0;
        frontend_clr = |clr_m;
        for (int p = 0; p < PIPE_NUM; p++) begin
            for (int s = 0; s < STAGE_NUM; s++) begin
                if (clr_m[p][s]) begin
                    for (int l = 0; l < PIPE_NUM; l++) begin
                        for (int t = 0; t < STAGE_NUM; t++)
                            if (t < s) clr_vec[l][t] = 1'b1;
                        if (pos_f(l, fl_q[s]) > pos_f(p, fl_q[s])) clr_vec[l][s] = 1'b1;
                    end
                    if (!clr_excl_self_i[p][s]) clr_vec[p][s] = 1'b1;
                end
            end
        end
    end

    // Occupancy advance: held stages drop killed slots, a stall boundary inserts a bubble
    always_comb begin
        valid_d = valid_q;
        fl_d    = fl_q;
        if (stg_stall[0]) begin
            for (int p = 0; p < PIPE_NUM; p++) valid_d[p][0] = valid_q[p][0] & ~clr_vec[p][0];
        end else begin
            for (int p = 0; p < PIPE_NUM; p++) valid_d[p][0] = issue_i[p] & issue_ready & ~frontend_clr;
            fl_d[0] = first_lane_i;
        end
        for (int s = 1; s < STAGE_NUM; s++) begin
            if (stg_stall[s]) begin
                for (int p = 0; p < PIPE_NUM; p++) valid_d[p][s] = valid_q[p][s] & ~clr_vec[p][s];
            end else if (stg_stall[s-1]) begin
                for (int p = 0; p < PIPE_NUM; p++) valid_d[p][s] = 1'b0;
            end else begin
                for (int p = 0; p < PIPE_NUM; p++) valid_d[p][s] = valid_q[p][s-1] & ~clr_vec[p][s-1];
                fl_d[s] = fl_q[s-1];
            end
        end
    end

    // Post-flush issue block: HOLD lasts FLUSH_HOLD cycles, a new clear restarts it
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            RUN: begin
                if (frontend_clr && FLUSH_HOLD > 0) begin
                    state_d = HOLD;
                    hold_d  = HOLD_INIT;
                end
            end
            HOLD: begin
                if (frontend_clr) begin
                    hold_d = HOLD_INIT;
                end else if (hold_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
        issue_ready = (state_q == RUN) & ~stg_stall[0] & ~frontend_clr;
    end

    // Saturating stall-cycle and clear-event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stg_stall[0] && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        if (frontend_clr && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            fl_q        <= '0;
            state_q     <= RUN;
            hold_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            fl_q        <= fl_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_vec_o    = stall_vec;
    assign clr_vec_o      = clr_vec;
    assign valid_o        = valid_q;
    assign issue_ready_o  = issue_ready;
    assign frontend_clr_o = frontend_clr;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;
endmodule
